// File: rtl/mem_arbiter_if.sv
// Client/memory bundle for the two-port memory arbiter.
// slave = arbiter side; master = the clients and memory that face it.
interface mem_arbiter_if;
  logic        o_c0_ready;
  logic [31:0] i_c0_addr;
  logic        i_c0_ren;
  logic        i_c0_wen;
  logic [31:0] i_c0_wdata;
  logic [31:0] o_c0_rdata;
  logic        o_c0_valid;

  logic        o_c1_ready;
  logic [31:0] i_c1_addr;
  logic        i_c1_ren;
  logic        i_c1_wen;
  logic [31:0] i_c1_wdata;
  logic [31:0] o_c1_rdata;
  logic        o_c1_valid;

  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_ren;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        i_mem_valid;

  modport slave (
    output o_c0_ready, o_c0_rdata, o_c0_valid,
    output o_c1_ready, o_c1_rdata, o_c1_valid,
    output o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata,
    input  i_c0_addr, i_c0_ren, i_c0_wen, i_c0_wdata,
    input  i_c1_addr, i_c1_ren, i_c1_wen, i_c1_wdata,
    input  i_mem_ready, i_mem_rdata, i_mem_valid
  );

  modport master (
    input  o_c0_ready, o_c0_rdata, o_c0_valid,
    input  o_c1_ready, o_c1_rdata, o_c1_valid,
    input  o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata,
    output i_c0_addr, i_c0_ren, i_c0_wen, i_c0_wdata,
    output i_c1_addr, i_c1_ren, i_c1_wen, i_c1_wdata,
    output i_mem_ready, i_mem_rdata, i_mem_valid
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter: one request slot per client, one read in flight.
// Issue >=1 cycle after capture; client ready depends only on its slot register.
module mem_arbiter (
  input  logic         i_clk,
  input  logic         i_rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic {IDLE, WAIT_RD} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       wr_q, wr_d;
  logic [1:0][31:0] addr_q, addr_d;
  logic [1:0][31:0] wdata_q, wdata_d;

  logic [1:0]       req;
  logic [1:0]       in_wr;
  logic [1:0][31:0] in_addr;
  logic [1:0][31:0] in_wdata;

  logic             issue, gnt, rsp;
  logic             mem_ren, mem_wen;
  logic [31:0]      mem_addr, mem_wdata;

  assign req      = {bus.i_c1_ren | bus.i_c1_wen, bus.i_c0_ren | bus.i_c0_wen};
  assign in_wr    = {bus.i_c1_wen, bus.i_c0_wen};
  assign in_addr  = {bus.i_c1_addr, bus.i_c0_addr};
  assign in_wdata = {bus.i_c1_wdata, bus.i_c0_wdata};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      pend_q  <= '0;
      wr_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    pend_d    = pend_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    issue     = 1'b0;
    gnt       = 1'b0;
    rsp       = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;

    case (state_q)
      IDLE: begin
        if (bus.i_mem_ready && (|pend_q)) begin
          issue = 1'b1;
          // On a tie the port not granted last wins; otherwise the lone pending port.
          gnt   = (&pend_q) ? ~last_q : pend_q[1];
        end
      end
      WAIT_RD: begin
        if (bus.i_mem_valid) begin
          rsp     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      pend_d[gnt] = 1'b0;
      last_d      = gnt;
      mem_ren     = ~wr_q[gnt];
      mem_wen     = wr_q[gnt];
      mem_addr    = addr_q[gnt];
      mem_wdata   = wdata_q[gnt];
      if (!wr_q[gnt]) begin
        state_d = WAIT_RD;
        owner_d = gnt;
      end
    end

    // A slot only captures while empty, so capture never collides with its own issue.
    for (int n = 0; n < 2; n++) begin
      if (!pend_q[n] && req[n]) begin
        pend_d[n]  = 1'b1;
        wr_d[n]    = in_wr[n];
        addr_d[n]  = in_addr[n];
        wdata_d[n] = in_wdata[n];
      end
    end
  end

  assign bus.o_c0_ready  = ~pend_q[0];
  assign bus.o_c1_ready  = ~pend_q[1];
  assign bus.o_c0_valid  = rsp & ~owner_q;
  assign bus.o_c1_valid  = rsp & owner_q;
  assign bus.o_c0_rdata  = (rsp && !owner_q) ? bus.i_mem_rdata : 32'h0;
  assign bus.o_c1_rdata  = (rsp && owner_q) ? bus.i_mem_rdata : 32'h0;
  assign bus.o_mem_ren   = mem_ren;
  assign bus.o_mem_wen   = mem_wen;
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_wdata = mem_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 2ns after the rising edge, outputs checked 1ns later.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic clr_in();
    bus.i_c0_addr = 32'h0; bus.i_c0_ren = 1'b0; bus.i_c0_wen = 1'b0; bus.i_c0_wdata = 32'h0;
    bus.i_c1_addr = 32'h0; bus.i_c1_ren = 1'b0; bus.i_c1_wen = 1'b0; bus.i_c1_wdata = 32'h0;
    bus.i_mem_ready = 1'b1; bus.i_mem_rdata = 32'h0; bus.i_mem_valid = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    clr_in();
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.o_c0_ready !== 1'b1 || bus.o_c1_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got c0=%b c1=%b want 1/1", bus.o_c0_ready, bus.o_c1_ready); end
    n_cmp++; if (bus.o_mem_ren !== 1'b0 || bus.o_mem_wen !== 1'b0) begin n_err++; $display("FAIL rst_renwen: got ren=%b wen=%b want 0/0", bus.o_mem_ren, bus.o_mem_wen); end
    n_cmp++; if (bus.o_mem_addr !== 32'h0 || bus.o_mem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_memdata: got addr=%h wdata=%h want 0/0", bus.o_mem_addr, bus.o_mem_wdata); end
    n_cmp++; if (bus.o_c0_valid !== 1'b0 || bus.o_c1_valid !== 1'b0 || bus.o_c0_rdata !== 32'h0 || bus.o_c1_rdata !== 32'h0) begin n_err++; $display("FAIL rst_client: got v0=%b v1=%b d0=%h d1=%h want all 0", bus.o_c0_valid, bus.o_c1_valid, bus.o_c0_rdata, bus.o_c1_rdata); end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    bus.i_c0_ren = 1'b1; bus.i_c0_addr = 32'h100;
    #1;
    n_cmp++; if (bus.o_mem_ren !== 1'b0) begin n_err++; $display("FAIL sr_no_same_cycle: got ren=%b want 0", bus.o_mem_ren); end
    nxt(); clr_in(); #1;
    n_cmp++; if (bus.o_mem_ren !== 1'b1 || bus.o_mem_addr !== 32'h100) begin n_err++; $display("FAIL sr_issue: got ren=%b addr=%h want 1/100", bus.o_mem_ren, bus.o_mem_addr); end
    n_cmp++; if (bus.o_c0_ready !== 1'b0) begin n_err++; $display("FAIL sr_ready_low: got %b want 0", bus.o_c0_ready); end
    nxt(); #1;
    n_cmp++; if (bus.o_c0_ready !== 1'b1 || bus.o_mem_ren !== 1'b0) begin n_err++; $display("FAIL sr_wait: got ready=%b ren=%b want 1/0", bus.o_c0_ready, bus.o_mem_ren); end
    nxt(); nxt();
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'hDEADBEEF; #1;
    n_cmp++; if (bus.o_c0_valid !== 1'b1 || bus.o_c0_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL sr_resp: got v=%b d=%h want 1/deadbeef", bus.o_c0_valid, bus.o_c0_rdata); end
    n_cmp++; if (bus.o_c1_valid !== 1'b0 || bus.o_c1_rdata !== 32'h0) begin n_err++; $display("FAIL sr_c1_quiet: got v=%b d=%h want 0/0", bus.o_c1_valid, bus.o_c1_rdata); end
    nxt(); clr_in();
  endtask

  task automatic test_tie();
    do_reset();
    bus.i_c0_ren = 1'b1; bus.i_c0_addr = 32'h200;
    bus.i_c1_wen = 1'b1; bus.i_c1_addr = 32'h300; bus.i_c1_wdata = 32'h12345678;
    nxt(); clr_in(); #1;
    n_cmp++; if (bus.o_mem_ren !== 1'b1 || bus.o_mem_wen !== 1'b0 || bus.o_mem_addr !== 32'h200) begin n_err++; $display("FAIL tie_first_c0: got ren=%b wen=%b addr=%h want 1/0/200", bus.o_mem_ren, bus.o_mem_wen, bus.o_mem_addr); end
    nxt();
    bus.i_c0_ren = 1'b1; bus.i_c0_addr = 32'h204; #1;
    n_cmp++; if (bus.o_mem_ren !== 1'b0 || bus.o_mem_wen !== 1'b0 || bus.o_c1_ready !== 1'b0) begin n_err++; $display("FAIL tie_hold: got ren=%b wen=%b c1rdy=%b want 0/0/0", bus.o_mem_ren, bus.o_mem_wen, bus.o_c1_ready); end
    nxt(); clr_in();
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'h11; #1;
    n_cmp++; if (bus.o_c0_valid !== 1'b1 || bus.o_c0_rdata !== 32'h11 || bus.o_mem_wen !== 1'b0) begin n_err++; $display("FAIL tie_resp: got v=%b d=%h wen=%b want 1/11/0", bus.o_c0_valid, bus.o_c0_rdata, bus.o_mem_wen); end
    nxt(); clr_in(); #1;
    n_cmp++; if (bus.o_mem_wen !== 1'b1 || bus.o_mem_ren !== 1'b0 || bus.o_mem_addr !== 32'h300 || bus.o_mem_wdata !== 32'h12345678) begin n_err++; $display("FAIL tie_second_c1: got wen=%b ren=%b addr=%h wd=%h want 1/0/300/12345678", bus.o_mem_wen, bus.o_mem_ren, bus.o_mem_addr, bus.o_mem_wdata); end
    nxt(); #1;
    n_cmp++; if (bus.o_mem_ren !== 1'b1 || bus.o_mem_addr !== 32'h204) begin n_err++; $display("FAIL tie_then_c0: got ren=%b addr=%h want 1/204", bus.o_mem_ren, bus.o_mem_addr); end
    nxt();
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'h22; #1;
    n_cmp++; if (bus.o_c0_valid !== 1'b1 || bus.o_c0_rdata !== 32'h22) begin n_err++; $display("FAIL tie_resp2: got v=%b d=%h want 1/22", bus.o_c0_valid, bus.o_c0_rdata); end
    nxt(); clr_in();
  endtask

  task automatic test_write_bypass();
    do_reset();
    bus.i_c1_wen = 1'b1; bus.i_c1_addr = 32'h40; bus.i_c1_wdata = 32'hA5A5A5A5;
    nxt(); clr_in();
    bus.i_c0_ren = 1'b1; bus.i_c0_addr = 32'h80; #1;
    n_cmp++; if (bus.o_mem_wen !== 1'b1 || bus.o_mem_ren !== 1'b0 || bus.o_mem_addr !== 32'h40 || bus.o_mem_wdata !== 32'hA5A5A5A5) begin n_err++; $display("FAIL wb_write: got wen=%b ren=%b addr=%h wd=%h want 1/0/40/a5a5a5a5", bus.o_mem_wen, bus.o_mem_ren, bus.o_mem_addr, bus.o_mem_wdata); end
    nxt(); clr_in(); #1;
    n_cmp++; if (bus.o_mem_ren !== 1'b1 || bus.o_mem_wen !== 1'b0 || bus.o_mem_addr !== 32'h80 || bus.o_mem_wdata !== 32'h0) begin n_err++; $display("FAIL wb_read: got ren=%b wen=%b addr=%h wd=%h want 1/0/80/0", bus.o_mem_ren, bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_wdata); end
    nxt();
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'h77; #1;
    n_cmp++; if (bus.o_c0_valid !== 1'b1 || bus.o_c0_rdata !== 32'h77) begin n_err++; $display("FAIL wb_resp: got v=%b d=%h want 1/77", bus.o_c0_valid, bus.o_c0_rdata); end
    nxt(); clr_in();
  endtask

  task automatic test_burst();
    do_reset();
    bus.i_c1_ren = 1'b1; bus.i_c1_addr = 32'h1000;
    for (int k = 0; k < 4; k++) begin
      nxt(); clr_in(); #1;
      n_cmp++; if (bus.o_mem_ren !== 1'b1 || bus.o_mem_addr !== 32'h1000 + 32'(4 * k)) begin n_err++; $display("FAIL burst_issue%0d: got ren=%b addr=%h want 1/%h", k, bus.o_mem_ren, bus.o_mem_addr, 32'h1000 + 32'(4 * k)); end
      nxt();
      bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'hC0DE0000 + 32'(k);
      if (k < 3) begin
        bus.i_c1_ren = 1'b1; bus.i_c1_addr = 32'h1004 + 32'(4 * k);
      end
      #1;
      n_cmp++; if (bus.o_c1_ready !== 1'b1) begin n_err++; $display("FAIL burst_ready%0d: got %b want 1", k, bus.o_c1_ready); end
      n_cmp++; if (bus.o_c1_valid !== 1'b1 || bus.o_c1_rdata !== 32'hC0DE0000 + 32'(k)) begin n_err++; $display("FAIL burst_resp%0d: got v=%b d=%h want 1/%h", k, bus.o_c1_valid, bus.o_c1_rdata, 32'hC0DE0000 + 32'(k)); end
      n_cmp++; if (bus.o_c0_valid !== 1'b0 || bus.o_c0_rdata !== 32'h0) begin n_err++; $display("FAIL burst_c0_quiet%0d: got v=%b d=%h want 0/0", k, bus.o_c0_valid, bus.o_c0_rdata); end
    end
    nxt(); clr_in();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.i_mem_ready = 1'b0;
    bus.i_c0_ren = 1'b1; bus.i_c0_addr = 32'h500;
    bus.i_c1_wen = 1'b1; bus.i_c1_addr = 32'h600; bus.i_c1_wdata = 32'hBBBB;
    for (int c = 0; c < 5; c++) begin
      nxt(); clr_in(); bus.i_mem_ready = 1'b0; #1;
      n_cmp++; if (bus.o_mem_ren !== 1'b0 || bus.o_mem_wen !== 1'b0) begin n_err++; $display("FAIL bp_stall%0d: got ren=%b wen=%b want 0/0", c, bus.o_mem_ren, bus.o_mem_wen); end
      n_cmp++; if (bus.o_c0_ready !== 1'b0 || bus.o_c1_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready%0d: got c0=%b c1=%b want 0/0", c, bus.o_c0_ready, bus.o_c1_ready); end
    end
    nxt(); clr_in(); #1;
    n_cmp++; if (bus.o_mem_ren !== 1'b1 || bus.o_mem_addr !== 32'h500) begin n_err++; $display("FAIL bp_release: got ren=%b addr=%h want 1/500", bus.o_mem_ren, bus.o_mem_addr); end
    nxt();
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'h99; #1;
    n_cmp++; if (bus.o_c0_valid !== 1'b1 || bus.o_c0_rdata !== 32'h99) begin n_err++; $display("FAIL bp_resp: got v=%b d=%h want 1/99", bus.o_c0_valid, bus.o_c0_rdata); end
    nxt(); clr_in(); #1;
    n_cmp++; if (bus.o_mem_wen !== 1'b1 || bus.o_mem_addr !== 32'h600 || bus.o_mem_wdata !== 32'hBBBB) begin n_err++; $display("FAIL bp_write: got wen=%b addr=%h wd=%h want 1/600/bbbb", bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_wdata); end
    nxt(); clr_in();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    bus.i_c0_ren = 1'b1; bus.i_c0_addr = 32'h700;
    nxt(); clr_in(); #1;
    n_cmp++; if (bus.o_mem_ren !== 1'b1 || bus.o_mem_addr !== 32'h700) begin n_err++; $display("FAIL rm_issue: got ren=%b addr=%h want 1/700", bus.o_mem_ren, bus.o_mem_addr); end
    nxt();
    rst = 1'b1; #1;
    n_cmp++; if (bus.o_c0_ready !== 1'b1 || bus.o_c1_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready: got c0=%b c1=%b want 1/1", bus.o_c0_ready, bus.o_c1_ready); end
    nxt();
    rst = 1'b0;
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'h55; #1;
    n_cmp++; if (bus.o_c0_valid !== 1'b0 || bus.o_c1_valid !== 1'b0) begin n_err++; $display("FAIL rm_no_valid: got v0=%b v1=%b want 0/0", bus.o_c0_valid, bus.o_c1_valid); end
    n_cmp++; if (bus.o_c0_rdata !== 32'h0 || bus.o_c1_rdata !== 32'h0) begin n_err++; $display("FAIL rm_no_data: got d0=%h d1=%h want 0/0", bus.o_c0_rdata, bus.o_c1_rdata); end
    nxt(); clr_in(); #1;
    n_cmp++; if (bus.o_c0_ready !== 1'b1 || bus.o_c1_ready !== 1'b1 || bus.o_mem_ren !== 1'b0) begin n_err++; $display("FAIL rm_idle: got c0=%b c1=%b ren=%b want 1/1/0", bus.o_c0_ready, bus.o_c1_ready, bus.o_mem_ren); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_write_bypass();
    test_burst();
    test_backpressure();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
